// File: rtl/flopr_en.sv
// flopr_en: WIDTH-bit D register with synchronous active-high reset and a
// load enable. The enable is a hold mux that feeds q back to its own input,
// so the clock always runs ungated and every bit of q changes only on the
// rising edge of clk.
module flopr_en #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_next;

    // Hold mux: load d when enabled, otherwise recirculate the current value.
    always_comb begin
        d_next = q;
        if (en) begin
            d_next = d;
        end
    end

    // State register. Reset is tested first so that an X or Z on en or d
    // cannot stop q from reaching RESET_VALUE while reset is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d_next;
        end
    end

endmodule

// File: tb/tb_flopr_en.sv
// Self-checking bench for flopr_en at WIDTH=32 (default reset value),
// WIDTH=8 (reset value 0xA5) and WIDTH=1. The reference model keeps one
// expected value per instance and updates it at each rising edge from the
// register rules: reset wins, otherwise en loads d, otherwise hold.
module tb_flopr_en;

    logic        clk;

    logic        reset32;
    logic        en32;
    logic [31:0] d32;
    logic [31:0] q32;

    logic        reset8;
    logic        en8;
    logic [7:0]  d8;
    logic [7:0]  q8;

    logic        reset1;
    logic        en1;
    logic [0:0]  d1;
    logic [0:0]  q1;

    logic [31:0] exp32;
    logic [7:0]  exp8;
    logic [0:0]  exp1;

    int checks;
    int passed;

    flopr_en dut32 (
        .clk   (clk),
        .reset (reset32),
        .en    (en32),
        .d     (d32),
        .q     (q32)
    );

    flopr_en #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .en    (en8),
        .d     (d8),
        .q     (q8)
    );

    flopr_en #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .en    (en1),
        .d     (d1),
        .q     (q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, update the reference model from the inputs
    // present at that edge, then step 1 time unit past the edge for sampling.
    task automatic tick();
        @(posedge clk);
        if (reset32 === 1'b1)   exp32 = 32'h0;
        else if (en32 === 1'b1) exp32 = d32;
        if (reset8 === 1'b1)    exp8 = 8'hA5;
        else if (en8 === 1'b1)  exp8 = d8;
        if (reset1 === 1'b1)    exp1 = 1'b0;
        else if (en1 === 1'b1)  exp1 = d1;
        #1;
    endtask

    task automatic test_reset();
        reset32 = 1'b1; en32 = 1'b1; d32 = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q32 !== 32'h0)
                $display("FAIL reset_edge%0d: q=%h expected=%h", i, q32, 32'h0);
            else
                passed++;
        end
        reset32 = 1'b1; en32 = 1'bx; d32 = 'x;
        tick();
        checks++;
        if (q32 !== 32'h0)
            $display("FAIL reset_with_x: q=%h expected=%h", q32, 32'h0);
        else
            passed++;
    endtask

    task automatic test_load();
        reset32 = 1'b0; en32 = 1'b1; d32 = 32'h0000_000A;
        tick();
        checks++;
        if (q32 !== 32'h0000_000A)
            $display("FAIL load_a: q=%h expected=%h", q32, 32'h0000_000A);
        else
            passed++;
        d32 = 32'h1234_5678;
        tick();
        checks++;
        if (q32 !== 32'h1234_5678)
            $display("FAIL load_b: q=%h expected=%h", q32, 32'h1234_5678);
        else
            passed++;
    endtask

    task automatic test_hold();
        en32 = 1'b0; d32 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q32 !== 32'h1234_5678)
                $display("FAIL hold_edge%0d: q=%h expected=%h", i, q32, 32'h1234_5678);
            else
                passed++;
        end
    endtask

    task automatic test_enable_toggle();
        logic        en_seq [5];
        logic [31:0] d_seq  [5];
        logic [31:0] q_seq  [5];
        en_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        d_seq  = '{32'd5, 32'd7, 32'd9, 32'd3, 32'd0};
        q_seq  = '{32'd5, 32'd5, 32'd9, 32'd9, 32'd0};
        reset32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en32 = en_seq[i];
            d32  = d_seq[i];
            tick();
            checks++;
            if (q32 !== q_seq[i])
                $display("FAIL toggle_step%0d: q=%0d expected=%0d", i, q32, q_seq[i]);
            else
                passed++;
        end
    endtask

    task automatic test_reset_priority();
        reset32 = 1'b0; en32 = 1'b1; d32 = 32'h0000_000F;
        tick();
        // A reset raised between edges must not reach q before the next edge.
        reset32 = 1'b1; en32 = 1'b1; d32 = 32'hAAAA_AAAA;
        #3;
        checks++;
        if (q32 !== 32'h0000_000F)
            $display("FAIL reset_sync: q=%h expected=%h", q32, 32'h0000_000F);
        else
            passed++;
        tick();
        checks++;
        if (q32 !== 32'h0)
            $display("FAIL reset_priority: q=%h expected=%h", q32, 32'h0);
        else
            passed++;
        reset32 = 1'b0; en32 = 1'b1; d32 = 32'h5555_5555;
        tick();
        checks++;
        if (q32 !== 32'h5555_5555)
            $display("FAIL reset_release: q=%h expected=%h", q32, 32'h5555_5555);
        else
            passed++;
    endtask

    task automatic test_width8();
        reset8 = 1'b1; en8 = 1'b0; d8 = 8'h00;
        tick();
        checks++;
        if (q8 !== 8'hA5)
            $display("FAIL w8_reset: q=%h expected=%h", q8, 8'hA5);
        else
            passed++;
        reset8 = 1'b0; en8 = 1'b1; d8 = 8'h3C;
        tick();
        checks++;
        if (q8 !== 8'h3C)
            $display("FAIL w8_load: q=%h expected=%h", q8, 8'h3C);
        else
            passed++;
    endtask

    task automatic test_width1();
        reset1 = 1'b1; en1 = 1'b0; d1 = 1'b1;
        tick();
        checks++;
        if (q1 !== 1'b0)
            $display("FAIL w1_reset: q=%b expected=%b", q1, 1'b0);
        else
            passed++;
        reset1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
        tick();
        checks++;
        if (q1 !== 1'b1)
            $display("FAIL w1_load: q=%b expected=%b", q1, 1'b1);
        else
            passed++;
        en1 = 1'b0; d1 = 1'b0;
        tick();
        checks++;
        if (q1 !== 1'b1)
            $display("FAIL w1_hold: q=%b expected=%b", q1, 1'b1);
        else
            passed++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            reset32 = ($urandom_range(0, 7) == 0);
            en32    = 1'($urandom);
            d32     = $urandom;
            reset8  = ($urandom_range(0, 7) == 0);
            en8     = 1'($urandom);
            d8      = 8'($urandom);
            reset1  = ($urandom_range(0, 7) == 0);
            en1     = 1'($urandom);
            d1      = 1'($urandom);
            tick();
            checks++;
            if (q32 !== exp32 || q8 !== exp8 || q1 !== exp1) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d: q32=%h q8=%h q1=%b expected q32=%h q8=%h q1=%b",
                             i, q32, q8, q1, exp32, exp8, exp1);
                errs++;
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset32 = 1'b1; en32 = 1'b0; d32 = '0;
        reset8  = 1'b1; en8  = 1'b0; d8  = '0;
        reset1  = 1'b1; en1  = 1'b0; d1  = '0;
        exp32 = 'x; exp8 = 'x; exp1 = 'x;
        #2;
        test_reset();
        test_load();
        test_hold();
        test_enable_toggle();
        test_reset_priority();
        test_width8();
        test_width1();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
